// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// It produces the stall/flush controls for every pipeline register and the
// EX-stage forwarding selects. A RUN/WAIT/ERR FSM holds the pipeline during
// multi-cycle data-memory accesses and stops it for good if one times out.
// Optional build macro PIPE_HAZARD_STALLCNT_EN adds a saturating 32-bit
// StallCycles counter output.
module pipe_hazard_ctrl #(
   parameter int RA          = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [RA-1:0] RA1_D,
   input  logic [RA-1:0] RA2_D,
   input  logic [RA-1:0] RA1_E,
   input  logic [RA-1:0] RA2_E,
   input  logic [RA-1:0] A3_E,
   input  logic [RA-1:0] A3_M,
   input  logic [RA-1:0] A3_W,
   input  logic          RF_WE_M,
   input  logic          RF_WE_W,
   input  logic          WBSelect_E,
   input  logic          BranchTaken_E,
   input  logic          MemReq_M,
   input  logic          MemReady,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          StallM,
   output logic          FlushD,
   output logic          FlushE,
   output logic          FlushW,
   output logic [1:0]    FwdA_E,
   output logic [1:0]    FwdB_E,
   output logic          MemTimeout
`ifdef PIPE_HAZARD_STALLCNT_EN
   ,output logic [31:0]  StallCycles
`endif
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [RA-1:0] PC_REG   = '1;  // R15 holds the PC, never forwarded

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_t;

   state_t        state_r, state_nxt;
   logic [CW-1:0] cnt_r, cnt_nxt;
   logic          timeout_r;
   logic          freeze;
   logic          ldstall;

   // Forwarding select: the MEM-stage ALU result is younger than WB, so it wins.
   function automatic logic [1:0] fwd_sel(
      input logic [RA-1:0] src,
      input logic          we_m,
      input logic [RA-1:0] dst_m,
      input logic          we_w,
      input logic [RA-1:0] dst_w
   );
      if (we_m && (dst_m == src) && (dst_m != PC_REG)) begin
         fwd_sel = 2'b10;
      end else if (we_w && (dst_w == src) && (dst_w != PC_REG)) begin
         fwd_sel = 2'b01;
      end else begin
         fwd_sel = 2'b00;
      end
   endfunction

   // Memory wait FSM: next state, wait counter and the freeze term.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      freeze    = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (MemReq_M && !MemReady) begin
               freeze    = 1'b1;
               state_nxt = ST_WAIT;
               cnt_nxt   = CW'(1);
            end else begin
               cnt_nxt   = '0;
            end
         end
         ST_WAIT: begin
            freeze = !MemReady;
            if (MemReady) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt = ST_ERR;
            end else begin
               cnt_nxt   = cnt_r + CW'(1);
            end
         end
         ST_ERR: begin
            freeze = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // FSM state, wait counter and sticky timeout flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_RUN;
         cnt_r     <= '0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         cnt_r     <= cnt_nxt;
         timeout_r <= timeout_r | (state_nxt == ST_ERR);
      end
   end

   assign ldstall    = WBSelect_E && ((A3_E == RA1_D) || (A3_E == RA2_D));
   assign MemTimeout = timeout_r;

   // Stall/flush priority: reset, then memory freeze, then branch, then load-use.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      FwdA_E = 2'b00;
      FwdB_E = 2'b00;
      if (RST) begin
         FwdA_E = 2'b00;
      end else begin
         FwdA_E = fwd_sel(RA1_E, RF_WE_M, A3_M, RF_WE_W, A3_W);
         FwdB_E = fwd_sel(RA2_E, RF_WE_M, A3_M, RF_WE_W, A3_W);
         if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (BranchTaken_E) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (ldstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else begin
            FlushW = 1'b0;
         end
      end
   end

`ifdef PIPE_HAZARD_STALLCNT_EN
   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         StallCycles <= 32'd0;
      end else if (StallF && (StallCycles != 32'hFFFF_FFFF)) begin
         StallCycles <= StallCycles + 32'd1;
      end else begin
         StallCycles <= StallCycles;
      end
   end
`endif

endmodule
